// File: rtl/seq_shift_ctrl_if.sv
// Request/result bundle for the multi-cycle shift sequencer.
// The master issues start with operands; the slave returns busy, done and the result.
interface seq_shift_ctrl_if #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
);
  logic             start;
  logic [2:0]       op;
  logic [AMT_W-1:0] amt;
  logic [WIDTH-1:0] dataIn;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out;

  modport master (output start, op, amt, dataIn, input busy, done, out);
  modport slave  (input start, op, amt, dataIn, output busy, done, out);
endinterface

// File: rtl/seq_shift_ctrl.sv
// Multi-cycle shift sequencer: applies the requested shift 2 bits per cycle,
// with a final 1-bit step for odd amounts, then publishes the result with a done pulse.
//
//   state | meaning
//   IDLE  | waiting for start
//   SHIFT | stepping the working register, busy high
//   DONE  | one-cycle done pulse, a new start is accepted here too
module seq_shift_ctrl #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
) (
  input  logic           clk,
  input  logic           rst,
  seq_shift_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] out_q;
  logic [2:0]       op_q;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, done_q;
  logic             step_two;

  function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] w,
                                                  input logic [2:0]       o,
                                                  input logic             two);
    logic [WIDTH-1:0] r;
    r = w;
    if (o[2]) begin
      r = two ? {w[1:0], w[WIDTH-1:2]} : {w[0], w[WIDTH-1:1]};
    end else begin
      case (o[1:0])
        2'd0:    r = two ? {w[WIDTH-3:0], w[WIDTH-1:WIDTH-2]} : {w[WIDTH-2:0], w[WIDTH-1]};
        2'd1:    r = two ? {w[WIDTH-3:0], 2'b00} : {w[WIDTH-2:0], 1'b0};
        2'd2:    r = two ? {{2{w[WIDTH-1]}}, w[WIDTH-1:2]} : {w[WIDTH-1], w[WIDTH-1:1]};
        default: r = two ? {2'b00, w[WIDTH-1:2]} : {1'b0, w[WIDTH-1:1]};
      endcase
    end
    return r;
  endfunction

  // A 1-bit step only happens when a single bit remains, so cnt never underflows.
  always_comb begin
    step_two = (cnt_q > AMT_W'(1));
    cnt_d    = step_two ? (cnt_q - AMT_W'(2)) : (cnt_q - AMT_W'(1));
    work_d   = shift_step(work_q, op_q, step_two);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      work_q  <= '0;
      out_q   <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          if (bus.start) begin
            work_q <= bus.dataIn;
            op_q   <= bus.op;
            cnt_q  <= bus.amt;
            if (bus.amt == '0) begin
              out_q   <= bus.dataIn;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              busy_q  <= 1'b1;
              state_q <= SHIFT;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        SHIFT: begin
          work_q <= work_d;
          cnt_q  <= cnt_d;
          if (cnt_d == '0) begin
            out_q   <= work_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.out  = out_q;

endmodule
